// File: rtl/rf_bank_responder.sv
// Register-file bank responder: queues tagged row reads, arbitrates the single array
// port between CDB writes (priority) and queued reads, and returns tagged row data.
module rf_bank_responder #(
    parameter int DATA_W     = 32,
    parameter int ROWS       = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_vld,
    input  logic [$clog2(ROWS)-1:0]  req_row,
    input  logic [1:0]               req_ocid,
    input  logic                     req_opnd,
    input  logic                     wr_en,
    input  logic [$clog2(ROWS)-1:0]  wr_row,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W-1:0]        bk_data,
    output logic                     bk_vld,
    output logic [1:0]               bk_ocid,
    output logic                     bk_opnd,
    output logic                     bk_bz,
    output logic                     cdb_bz
);

    localparam int ROW_W = $clog2(ROWS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SC_W  = $clog2(STARVE_MAX + 1);
    localparam int ENT_W = ROW_W + 3;

    // Request queue storage: {row, ocid, opnd}
    logic [ENT_W-1:0]  r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_bk_bz;

    logic [DATA_W-1:0] r_mem [ROWS];

    logic [SC_W-1:0]   r_starve;
    logic              r_cdb_bz;

    logic [DATA_W-1:0] r_bk_data_p1;
    logic [1:0]        r_bk_ocid_p1;
    logic              r_bk_opnd_p1;
    logic              r_vld_p1;

    logic              w_push;
    logic              w_nonempty;
    logic              w_pop;
    logic              w_blocked;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [ENT_W-1:0]  w_head;
    logic [ROW_W-1:0]  w_head_row;
    logic [1:0]        w_head_ocid;
    logic              w_head_opnd;
    logic [SC_W-1:0]   w_starve_inc;

    // bk_bz is the registered full flag, so a full queue rejects even when a pop coincides.
    assign w_push       = req_vld && !r_bk_bz;
    assign w_nonempty   = (r_count != '0);
    assign w_pop        = !wr_en && w_nonempty;
    assign w_blocked    = wr_en && w_nonempty;
    assign w_head       = r_fifo[r_rd_ptr];
    assign w_head_row   = w_head[ENT_W-1 -: ROW_W];
    assign w_head_ocid  = w_head[2:1];
    assign w_head_opnd  = w_head[0];
    assign w_starve_inc = r_starve + SC_W'(1);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {req_row, req_ocid, req_opnd};
        end
    end

    // Stage p0 -> p1: array port arbitration, queue bookkeeping, registered return
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_bk_bz      <= 1'b0;
            r_starve     <= '0;
            r_cdb_bz     <= 1'b0;
            r_vld_p1     <= 1'b0;
            r_bk_data_p1 <= '0;
            r_bk_ocid_p1 <= '0;
            r_bk_opnd_p1 <= 1'b0;
            for (int i = 0; i < ROWS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            r_bk_bz <= (w_count_nxt == CNT_W'(FIFO_DEPTH));

            if (wr_en) begin
                r_mem[wr_row] <= wr_data;
            end

            r_vld_p1 <= w_pop;
            if (w_pop) begin
                r_bk_data_p1 <= r_mem[w_head_row];
                r_bk_ocid_p1 <= w_head_ocid;
                r_bk_opnd_p1 <= w_head_opnd;
            end

            if (w_blocked) begin
                if (w_starve_inc == SC_W'(STARVE_MAX)) begin
                    r_starve <= '0;
                    r_cdb_bz <= 1'b1;
                end else begin
                    r_starve <= w_starve_inc;
                    r_cdb_bz <= 1'b0;
                end
            end else begin
                r_starve <= '0;
                r_cdb_bz <= 1'b0;
            end
        end
    end

    assign bk_data = r_bk_data_p1;
    assign bk_vld  = r_vld_p1;
    assign bk_ocid = r_bk_ocid_p1;
    assign bk_opnd = r_bk_opnd_p1;
    assign bk_bz   = r_bk_bz;
    assign cdb_bz  = r_cdb_bz;

endmodule
